// File: rtl/sccb_init_pkg.sv
// Shared definitions for the SCCB register-table initialiser.
// Holds the FSM encoding, the delay marker and the frame layout helper.
package sccb_init_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, STRT, BITS, STOP, GAP, DLY, FIN
  } state_t;

  localparam logic [7:0]  DELAY_MARK = 8'hF0;
  localparam int unsigned FRAME_LEN  = 27;

  // Don't-care bit slots are encoded as 1 so the line is released during them
  function automatic logic [FRAME_LEN-1:0] make_frame(input logic [7:0] dev,
                                                      input logic [7:0] addr,
                                                      input logic [7:0] data);
    return {dev, 1'b1, addr, 1'b1, data, 1'b1};
  endfunction

endpackage

// File: rtl/sccb_init_if.sv
// Host-facing control and SCCB line bundle of the initialiser.
interface sccb_init_if;
  logic       start;
  logic       sioc;
  logic       siod_oe;
  logic       busy;
  logic       done;
  logic [5:0] idx;

  modport master (input start, output sioc, output siod_oe, output busy, output done, output idx);
  modport slave  (output start, input sioc, input siod_oe, input busy, input done, input idx);
endinterface

// File: rtl/sccb_rom.sv
// Camera init table: 6-bit index to {addr,data}, registered output.
// An entry whose address is DELAY_MARK requests a pause instead of a write.
module sccb_rom
  import sccb_init_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  addr,
  output logic [15:0] data
);

  logic [15:0] rom_val;

  always_comb begin
    rom_val = {DELAY_MARK, 8'h00};
    case (addr)
      6'd0:  rom_val = 16'h1280;
      6'd1:  rom_val = {DELAY_MARK, 8'h00};
      6'd2:  rom_val = 16'h1101;
      6'd3:  rom_val = 16'h1204;
      6'd4:  rom_val = 16'h0C00;
      6'd5:  rom_val = 16'h3E00;
      6'd6:  rom_val = 16'h8C00;
      6'd7:  rom_val = 16'h0400;
      6'd8:  rom_val = 16'h40D0;
      6'd9:  rom_val = 16'h3A04;
      6'd10: rom_val = 16'h1418;
      6'd11: rom_val = 16'h4FB3;
      6'd12: rom_val = 16'h50B3;
      6'd13: rom_val = 16'h5100;
      6'd14: rom_val = 16'h523D;
      6'd15: rom_val = 16'h53A7;
      6'd16: rom_val = 16'h54E4;
      6'd17: rom_val = 16'h589E;
      6'd18: rom_val = 16'h3DC0;
      6'd19: rom_val = 16'h1714;
      6'd20: rom_val = 16'h1802;
      6'd21: rom_val = 16'h3280;
      6'd22: rom_val = 16'h1903;
      6'd23: rom_val = 16'h1A7B;
      6'd24: rom_val = 16'h030A;
      6'd25: rom_val = 16'h0F41;
      6'd26: rom_val = 16'h1E00;
      6'd27: rom_val = 16'h330B;
      6'd28: rom_val = 16'h3C78;
      6'd29: rom_val = 16'h6900;
      6'd30: rom_val = 16'h7400;
      6'd31: rom_val = 16'hB084;
      default: rom_val = {DELAY_MARK, 8'h00};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data <= '0;
    else     data <= rom_val;
  end

endmodule

// File: rtl/sccb_init.sv
// Walks the init ROM and writes each entry as a 3-phase SCCB write.
// All line changes happen on quarter-ticks of the SIO_C period.
module sccb_init
  import sccb_init_pkg::*;
#(
  parameter int unsigned QUARTER  = 125,
  parameter logic [7:0]  DEV_ID   = 8'h42,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DELAY_Q  = 40000
) (
  input  logic          clk,
  input  logic          rst,
  sccb_init_if.master   bus
);

  localparam int unsigned QW = $clog2(QUARTER);
  localparam int unsigned DW = $clog2(DELAY_Q + 1);
  localparam logic [QW-1:0] Q_LAST   = QW'(QUARTER - 1);
  localparam logic [DW-1:0] D_LAST   = DW'(DELAY_Q - 1);
  localparam logic [5:0]    IDX_LAST = 6'(NUM_REGS - 1);

  state_t               state;
  logic [QW-1:0]        qcnt;
  logic                 tick;
  logic [1:0]           ph;
  logic [4:0]           bitcnt;
  logic [DW-1:0]        dcnt;
  logic [FRAME_LEN-1:0] frame;
  logic                 sioc;
  logic                 siod_oe;
  logic                 busy;
  logic                 done;
  logic [5:0]           idx;
  logic [15:0]          rom_q;

  sccb_rom u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (idx),
    .data (rom_q)
  );

  assign tick = (qcnt == Q_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      qcnt    <= '0;
      ph      <= '0;
      bitcnt  <= '0;
      dcnt    <= '0;
      frame   <= '0;
      sioc    <= 1'b1;
      siod_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      idx     <= '0;
    end else begin
      // busy is low exactly in IDLE and FIN, so the counter rests at 0 there
      qcnt <= (busy && !tick) ? qcnt + 1'b1 : '0;
      unique case (state)
        IDLE: if (bus.start) begin
          state <= LOAD;
          idx   <= '0;
          ph    <= '0;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
        LOAD: begin
          ph <= 2'd1;
          if (ph[0]) begin
            // ROM output for the current index is valid on the second LOAD cycle
            qcnt <= '0;
            ph   <= '0;
            if (rom_q[15:8] == DELAY_MARK) begin
              state <= DLY;
              dcnt  <= '0;
            end else begin
              state <= STRT;
              frame <= make_frame(DEV_ID, rom_q[15:8], rom_q[7:0]);
            end
          end
        end
        STRT: if (tick) begin
          if (ph == 2'd0) begin
            siod_oe <= 1'b1;
            ph      <= 2'd1;
          end else begin
            sioc   <= 1'b0;
            ph     <= '0;
            bitcnt <= 5'(FRAME_LEN - 1);
            state  <= BITS;
          end
        end
        BITS: if (tick) begin
          ph <= ph + 2'd1;
          case (ph)
            2'd0:    sioc    <= 1'b0;
            2'd1:    siod_oe <= ~frame[bitcnt];
            2'd2:    sioc    <= 1'b1;
            default: if (bitcnt == '0) state <= STOP;
                     else bitcnt <= bitcnt - 5'd1;
          endcase
        end
        STOP: if (tick) begin
          ph <= ph + 2'd1;
          case (ph)
            2'd0: begin
              sioc    <= 1'b0;
              siod_oe <= 1'b1;
            end
            2'd1:    sioc <= 1'b1;
            2'd2:    ;
            default: begin
              siod_oe <= 1'b0;
              state   <= GAP;
            end
          endcase
        end
        GAP, DLY: if (tick) begin
          if (state == GAP) ph   <= ph + 2'd1;
          else              dcnt <= dcnt + 1'b1;
          // A finished delay ends the entry exactly like the end of a gap
          if ((state == GAP && ph == 2'd3) || (state == DLY && dcnt == D_LAST)) begin
            ph   <= '0;
            dcnt <= '0;
            if (idx == IDX_LAST) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 6'd1;
              state <= LOAD;
            end
          end
        end
        FIN: state <= IDLE;
      endcase
    end
  end

  assign bus.sioc    = sioc;
  assign bus.siod_oe = siod_oe;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.idx     = idx;

endmodule
